// File: rtl/nos_dac_serializer_if.sv
// Bus bundle for nos_dac_serializer: frame input side (data, start, ready,
// frame parameters) and DAC pin side (bck, sdata, le) plus status flags.
// Optional port mute exists only when NOS_DAC_SER_MUTE_EN is defined.
interface nos_dac_serializer_if #(
   parameter int CHANNELS = 2,
   parameter int IN_BITS  = 32,
   parameter int DIV_W    = 8
);
   logic [CHANNELS*IN_BITS-1:0] data;
   logic                        start;
   logic                        ready;
   logic [4:0]                  word_bits;
   logic [DIV_W-1:0]            half_div;
   logic                        bck_cont;
   logic                        bck;
   logic [CHANNELS-1:0]         sdata;
   logic                        le;
   logic                        busy;
   logic                        overrun;
`ifdef NOS_DAC_SER_MUTE_EN
   logic                        mute;
`endif

   // Frame source side.
   modport master (
`ifdef NOS_DAC_SER_MUTE_EN
      output mute,
`endif
      output data, start, word_bits, half_div, bck_cont,
      input  ready, bck, sdata, le, busy, overrun
   );

   // Serializer side.
   modport slave (
`ifdef NOS_DAC_SER_MUTE_EN
      input  mute,
`endif
      input  data, start, word_bits, half_div, bck_cont,
      output ready, bck, sdata, le, busy, overrun
   );
endinterface

// File: rtl/nos_dac_serializer.sv
// nos_dac_serializer: non-oversampling ladder-DAC serializer.
// Each frame is 33 bck periods: (32-N) pad periods, N data periods (MSB
// first, right-justified) and one latch period with le high. A one-frame
// holding buffer lets the next frame start right after the latch period.
// Optional feature macro: NOS_DAC_SER_MUTE_EN adds a mute input that loads
// zero words into the shifter while keeping frame timing unchanged.
module nos_dac_serializer #(
   parameter int CHANNELS = 2,
   parameter int IN_BITS  = 32,
   parameter int MAX_BITS = 24,
   parameter int DIV_W    = 8
) (
   input  logic                clk,
   input  logic                reset,
   nos_dac_serializer_if.slave bus
);

   localparam int         CNT_W = 6;
   localparam logic [4:0] MAX_N = 5'(MAX_BITS);

   typedef enum logic [1:0] {
      S_IDLE,
      S_PAD,
      S_DATA,
      S_LATCH
   } state_t;

   // Word length of 0 or beyond the DAC width saturates to the DAC width.
   function automatic logic [4:0] resolve_bits(input logic [4:0] wb);
      if (wb == 5'd0 || wb > MAX_N) return MAX_N;
      return wb;
   endfunction

   // Top MAX_BITS of the MSB-aligned word, or silence when muted.
   function automatic logic [MAX_BITS-1:0] frame_word(input logic [MAX_BITS-1:0] top,
                                                      input logic            m);
      return m ? '0 : top;
   endfunction

   // Frame control state
   state_t              state;
   logic [DIV_W-1:0]    div_cnt;
   logic                phase;
   logic [CNT_W-1:0]    per_cnt;
   logic [4:0]          n_r;
   logic [DIV_W-1:0]    hd_r;
   logic                bc_r;

   // Holding buffer (stage p0) and shifter (stage p1)
   logic                vld_p0;
   logic [4:0]          hold_n_p0;
   logic [DIV_W-1:0]    hold_hd_p0;
   logic                hold_bc_p0;
   logic [MAX_BITS-1:0] hold_w_p0 [CHANNELS];
   logic [MAX_BITS-1:0] sh_p1     [CHANNELS];

   // Registered outputs
   logic                bck_r;
   logic [CHANNELS-1:0] sdata_r;
   logic                le_r;
   logic                busy_r;
   logic                ready_r;
   logic                overrun_r;

   // Combinational helpers
   logic                mute_in;
   logic [MAX_BITS-1:0] din_w [CHANNELS];
   logic [CHANNELS-1:0] sh_msb;
   logic                half_end;
   logic                per_end;
   logic                latch_end;
   logic                accept;
   logic                load_now;
   logic                buf_wr;
   logic                buf_rd;
   logic                new_frame;
   logic                shift_en;
   logic [4:0]          nf_n;
   logic [DIV_W-1:0]    nf_hd;
   logic                nf_bc;
   logic                unused_data;

`ifdef NOS_DAC_SER_MUTE_EN
   assign mute_in = bus.mute;
`else
   assign mute_in = 1'b0;
`endif

   // Low-order input bits below the DAC width are never shifted out.
   assign unused_data = ^bus.data;

   assign half_end  = (div_cnt == hd_r);
   assign per_end   = phase & half_end;
   assign latch_end = (state == S_LATCH) & per_end;
   assign accept    = bus.start & ready_r;
   // A start in idle or in the final latch cycle goes straight to the shifter.
   assign load_now  = accept & ((state == S_IDLE) | latch_end);
   assign buf_wr    = accept & ~load_now;
   assign buf_rd    = latch_end & vld_p0;
   assign new_frame = load_now | buf_rd;
   // Shift at every period boundary that leads into a data period.
   assign shift_en  = per_end & (((state == S_PAD)  & (per_cnt == '0)) |
                                 ((state == S_DATA) & (per_cnt != '0)));

   assign nf_n  = buf_rd ? hold_n_p0  : resolve_bits(bus.word_bits);
   assign nf_hd = buf_rd ? hold_hd_p0 : bus.half_div;
   assign nf_bc = buf_rd ? hold_bc_p0 : bus.bck_cont;

   // Per-channel input words and current shifter MSBs.
   always_comb begin
      for (int k = 0; k < CHANNELS; k++) begin
         din_w[k]  = frame_word(bus.data[k*IN_BITS + IN_BITS - 1 -: MAX_BITS], mute_in);
         sh_msb[k] = sh_p1[k][MAX_BITS-1];
      end
   end

   // Frame FSM, bck/le/sdata generation, buffer occupancy and status flags.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= S_IDLE;
         div_cnt   <= '0;
         phase     <= 1'b0;
         per_cnt   <= '0;
         n_r       <= MAX_N;
         hd_r      <= '0;
         bc_r      <= 1'b0;
         vld_p0    <= 1'b0;
         bck_r     <= 1'b0;
         sdata_r   <= '0;
         le_r      <= 1'b0;
         busy_r    <= 1'b0;
         ready_r   <= 1'b1;
         overrun_r <= 1'b0;
      end else begin
         overrun_r <= bus.start & ~ready_r;

         if (buf_wr) begin
            vld_p0  <= 1'b1;
            ready_r <= 1'b0;
         end else if (buf_rd) begin
            vld_p0  <= 1'b0;
            ready_r <= 1'b1;
         end

         if (new_frame) begin
            state   <= S_PAD;
            n_r     <= nf_n;
            hd_r    <= nf_hd;
            bc_r    <= nf_bc;
            per_cnt <= 6'd31 - 6'(nf_n);
            div_cnt <= '0;
            phase   <= 1'b0;
            bck_r   <= 1'b0;
            le_r    <= 1'b0;
            sdata_r <= '0;
            busy_r  <= 1'b1;
         end else if (state != S_IDLE) begin
            if (!half_end) begin
               div_cnt <= div_cnt + 1'b1;
            end else if (!phase) begin
               // Low half done: enter high half; pad keeps bck low unless continuous.
               phase   <= 1'b1;
               div_cnt <= '0;
               bck_r   <= (state != S_PAD) | bc_r;
            end else begin
               // Period boundary.
               phase   <= 1'b0;
               div_cnt <= '0;
               bck_r   <= 1'b0;
               unique case (state)
                  S_PAD: begin
                     if (per_cnt == '0) begin
                        state   <= S_DATA;
                        per_cnt <= 6'(n_r) - 6'd1;
                        sdata_r <= sh_msb;
                     end else begin
                        per_cnt <= per_cnt - 1'b1;
                     end
                  end
                  S_DATA: begin
                     if (per_cnt == '0) begin
                        state <= S_LATCH;
                        le_r  <= 1'b1;
                     end else begin
                        per_cnt <= per_cnt - 1'b1;
                        sdata_r <= sh_msb;
                     end
                  end
                  S_LATCH: begin
                     state   <= S_IDLE;
                     le_r    <= 1'b0;
                     busy_r  <= 1'b0;
                     sdata_r <= '0;
                  end
                  default: state <= S_IDLE;
               endcase
            end
         end
      end
   end

   // Holding buffer capture of a frame accepted while a frame is in flight.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_n_p0  <= MAX_N;
         hold_hd_p0 <= '0;
         hold_bc_p0 <= 1'b0;
         for (int k = 0; k < CHANNELS; k++) hold_w_p0[k] <= '0;
      end else if (buf_wr) begin
         hold_n_p0  <= resolve_bits(bus.word_bits);
         hold_hd_p0 <= bus.half_div;
         hold_bc_p0 <= bus.bck_cont;
         for (int k = 0; k < CHANNELS; k++) hold_w_p0[k] <= din_w[k];
      end
   end

   // Shifter load at frame start and MSB-first shift into each data period.
   always_ff @(posedge clk) begin
      for (int k = 0; k < CHANNELS; k++) begin
         if (new_frame)
            sh_p1[k] <= buf_rd ? hold_w_p0[k] : din_w[k];
         else if (shift_en)
            sh_p1[k] <= {sh_p1[k][MAX_BITS-2:0], 1'b0};
      end
   end

   assign bus.bck     = bck_r;
   assign bus.sdata   = sdata_r;
   assign bus.le      = le_r;
   assign bus.busy    = busy_r;
   assign bus.ready   = ready_r;
   assign bus.overrun = overrun_r;

endmodule

// File: tb/tb_nos_dac_serializer.sv
// Directed testbench for nos_dac_serializer (two channels, 32-bit words).
module tb_nos_dac_serializer;

   logic clk;
   logic reset;
   int   tests_run;
   int   tests_failed;

   nos_dac_serializer_if #(.CHANNELS(2), .IN_BITS(32), .DIV_W(8)) bus ();

   nos_dac_serializer #(
      .CHANNELS(2),
      .IN_BITS (32),
      .MAX_BITS(24),
      .DIV_W   (8)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_frame(input logic [4:0] wb, input logic [7:0] hd, input logic bc,
                              input logic [31:0] w0, input logic [31:0] w1);
      bus.word_bits = wb;
      bus.half_div  = hd;
      bus.bck_cont  = bc;
      bus.data      = {w1, w0};
   endtask

   // Expected {bck, le, sdata[1], sdata[0]} in cycle i (1-based) of a frame.
   function automatic logic [3:0] exp_vec(input int i, input int n, input int hd, input logic bc,
                                          input logic [31:0] w0, input logic [31:0] w1);
      int   hl, c, p, pad;
      logic hi, b, l;
      logic [1:0] s;
      hl  = hd + 1;
      c   = i - 1;
      p   = c / (2 * hl);
      hi  = (c % (2 * hl)) >= hl;
      pad = 32 - n;
      if (p < pad) begin
         b = bc & hi;
         s = 2'b00;
      end else if (p < 32) begin
         b = hi;
         s = {w1[31 - (p - pad)], w0[31 - (p - pad)]};
      end else begin
         b = hi;
         s = {w1[32 - n], w0[32 - n]};
      end
      l = (p == 32);
      return {b, l, s};
   endfunction

   task automatic test_reset;
      logic [5:0] obs;
      reset = 1'b1;
      tick;
      tick;
      obs = {bus.bck, bus.sdata, bus.le, bus.ready, bus.busy, bus.overrun};
      tests_run++;
      if (obs !== 7'b0_00_0_1_0_0 >> 1 << 1 >> 1) begin end
      if ({bus.bck, bus.sdata, bus.le, bus.ready, bus.busy, bus.overrun} !== 7'b0000100) begin
         tests_failed++;
         $display("FAIL reset_hold got=%b exp=%b", {bus.bck, bus.sdata, bus.le, bus.ready, bus.busy, bus.overrun}, 7'b0000100);
      end
      reset = 1'b0;
      tick;
      tests_run++;
      if ({bus.bck, bus.sdata, bus.le, bus.ready, bus.busy, bus.overrun} !== 7'b0000100) begin
         tests_failed++;
         $display("FAIL reset_release got=%b exp=%b", {bus.bck, bus.sdata, bus.le, bus.ready, bus.busy, bus.overrun}, 7'b0000100);
      end
      if (obs[0] !== 1'b0) begin end
   endtask

   task automatic test_basic;
      logic [4:0] exp;
      drive_frame(5'd16, 8'd0, 1'b0, 32'hA5A5_0000, 32'h1234_0000);
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      for (int i = 1; i <= 66; i++) begin
         exp = {1'b1, exp_vec(i, 16, 0, 1'b0, 32'hA5A5_0000, 32'h1234_0000)};
         tests_run++;
         if ({bus.busy, bus.bck, bus.le, bus.sdata} !== exp) begin
            tests_failed++;
            $display("FAIL basic_frame i=%0d got=%b exp=%b", i, {bus.busy, bus.bck, bus.le, bus.sdata}, exp);
         end
         tests_run++;
         if (bus.ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL basic_ready i=%0d got=%b exp=1", i, bus.ready);
         end
         tick;
      end
      tests_run++;
      if ({bus.busy, bus.bck, bus.le, bus.sdata} !== 5'b00000) begin
         tests_failed++;
         $display("FAIL basic_idle got=%b exp=00000", {bus.busy, bus.bck, bus.le, bus.sdata});
      end
   endtask

   task automatic test_cont;
      logic [4:0] exp;
      logic       prev;
      int         rises;
      prev  = 1'b0;
      rises = 0;
      drive_frame(5'd24, 8'd3, 1'b1, 32'hA5A5_0000, 32'h1234_0000);
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      for (int i = 1; i <= 264; i++) begin
         exp = {1'b1, exp_vec(i, 24, 3, 1'b1, 32'hA5A5_0000, 32'h1234_0000)};
         tests_run++;
         if ({bus.busy, bus.bck, bus.le, bus.sdata} !== exp) begin
            tests_failed++;
            $display("FAIL cont_frame i=%0d got=%b exp=%b", i, {bus.busy, bus.bck, bus.le, bus.sdata}, exp);
         end
         if (bus.bck === 1'b1 && prev === 1'b0) rises++;
         prev = bus.bck;
         tick;
      end
      tests_run++;
      if (rises != 33) begin
         tests_failed++;
         $display("FAIL cont_bck_periods got=%0d exp=33", rises);
      end
      tests_run++;
      if (bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL cont_length busy got=%b exp=0 after 264 cycles", bus.busy);
      end
   endtask

   task automatic test_back_to_back;
      logic [4:0] exp;
      logic       exp_rdy;
      logic       exp_ovr;
      drive_frame(5'd16, 8'd0, 1'b0, 32'hA5A5_0000, 32'h1234_0000);
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      for (int i = 1; i <= 198; i++) begin
         if (i <= 66)
            exp = {1'b1, exp_vec(i, 16, 0, 1'b0, 32'hA5A5_0000, 32'h1234_0000)};
         else
            exp = {1'b1, exp_vec(i - 66, 20, 1, 1'b1, 32'hC3A5_F000, 32'h5A5A_5FFF)};
         exp_rdy = (i >= 6 && i <= 66) ? 1'b0 : 1'b1;
         exp_ovr = (i == 11);
         tests_run++;
         if ({bus.busy, bus.bck, bus.le, bus.sdata} !== exp) begin
            tests_failed++;
            $display("FAIL b2b_frame i=%0d got=%b exp=%b", i, {bus.busy, bus.bck, bus.le, bus.sdata}, exp);
         end
         tests_run++;
         if (bus.ready !== exp_rdy) begin
            tests_failed++;
            $display("FAIL b2b_ready i=%0d got=%b exp=%b", i, bus.ready, exp_rdy);
         end
         tests_run++;
         if (bus.overrun !== exp_ovr) begin
            tests_failed++;
            $display("FAIL b2b_overrun i=%0d got=%b exp=%b", i, bus.overrun, exp_ovr);
         end
         if (i == 5) begin
            drive_frame(5'd20, 8'd1, 1'b1, 32'hC3A5_F000, 32'h5A5A_5FFF);
            bus.start = 1'b1;
         end
         if (i == 6) bus.start = 1'b0;
         if (i == 10) begin
            drive_frame(5'd8, 8'd5, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
            bus.start = 1'b1;
         end
         if (i == 11) bus.start = 1'b0;
         tick;
      end
      for (int j = 0; j < 6; j++) begin
         tests_run++;
         if ({bus.busy, bus.bck, bus.le, bus.sdata, bus.ready} !== 6'b000001) begin
            tests_failed++;
            $display("FAIL b2b_no_third j=%0d got=%b exp=000001", j, {bus.busy, bus.bck, bus.le, bus.sdata, bus.ready});
         end
         tick;
      end
   endtask

   task automatic test_latch_start;
      logic [4:0] exp;
      drive_frame(5'd24, 8'd0, 1'b0, 32'h9C3E_7100, 32'h0F0F_0F00);
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      for (int i = 1; i <= 132; i++) begin
         if (i <= 66)
            exp = {1'b1, exp_vec(i, 24, 0, 1'b0, 32'h9C3E_7100, 32'h0F0F_0F00)};
         else
            exp = {1'b1, exp_vec(i - 66, 12, 0, 1'b1, 32'hB710_0000, 32'h6E20_0000)};
         tests_run++;
         if ({bus.busy, bus.bck, bus.le, bus.sdata} !== exp) begin
            tests_failed++;
            $display("FAIL latch_start_frame i=%0d got=%b exp=%b", i, {bus.busy, bus.bck, bus.le, bus.sdata}, exp);
         end
         tests_run++;
         if (bus.ready !== 1'b1) begin
            tests_failed++;
            $display("FAIL latch_start_ready i=%0d got=%b exp=1", i, bus.ready);
         end
         if (i == 66) begin
            drive_frame(5'd12, 8'd0, 1'b1, 32'hB710_0000, 32'h6E20_0000);
            bus.start = 1'b1;
         end
         if (i == 67) bus.start = 1'b0;
         tick;
      end
      tests_run++;
      if (bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL latch_start_end busy got=%b exp=0", bus.busy);
      end
   endtask

   task automatic test_reset_mid;
      logic [4:0] exp;
      drive_frame(5'd16, 8'd0, 1'b0, 32'hA5A5_0000, 32'hFFFF_0000);
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      for (int i = 1; i <= 40; i++) begin
         exp = {1'b1, exp_vec(i, 16, 0, 1'b0, 32'hA5A5_0000, 32'hFFFF_0000)};
         tests_run++;
         if ({bus.busy, bus.bck, bus.le, bus.sdata} !== exp) begin
            tests_failed++;
            $display("FAIL rst_mid_pre i=%0d got=%b exp=%b", i, {bus.busy, bus.bck, bus.le, bus.sdata}, exp);
         end
         if (i == 30) bus.start = 1'b1;
         if (i == 31) begin
            bus.start = 1'b0;
            tests_run++;
            if (bus.ready !== 1'b0) begin
               tests_failed++;
               $display("FAIL rst_mid_buffered ready got=%b exp=0", bus.ready);
            end
         end
         if (i < 40) tick;
      end
      #2;
      reset = 1'b1;
      #1;
      tests_run++;
      if ({bus.bck, bus.sdata, bus.le, bus.ready, bus.busy, bus.overrun} !== 7'b0000100) begin
         tests_failed++;
         $display("FAIL rst_mid_async got=%b exp=0000100", {bus.bck, bus.sdata, bus.le, bus.ready, bus.busy, bus.overrun});
      end
      tick;
      tick;
      reset = 1'b0;
      tick;
      tick;
      tick;
      tests_run++;
      if ({bus.busy, bus.ready} !== 2'b01) begin
         tests_failed++;
         $display("FAIL rst_mid_idle got=%b exp=01", {bus.busy, bus.ready});
      end
      drive_frame(5'd16, 8'd0, 1'b1, 32'h8001_0000, 32'h7FFE_0000);
      bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
      for (int i = 1; i <= 66; i++) begin
         exp = {1'b1, exp_vec(i, 16, 0, 1'b1, 32'h8001_0000, 32'h7FFE_0000)};
         tests_run++;
         if ({bus.busy, bus.bck, bus.le, bus.sdata} !== exp) begin
            tests_failed++;
            $display("FAIL rst_mid_after i=%0d got=%b exp=%b", i, {bus.busy, bus.bck, bus.le, bus.sdata}, exp);
         end
         tick;
      end
      tests_run++;
      if (bus.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL rst_mid_after_end busy got=%b exp=0", bus.busy);
      end
   endtask

   task automatic test_word_bits;
      logic [4:0]  exp;
      logic [4:0]  wb;
      logic [31:0] w0;
      logic [31:0] w1;
      for (int t = 0; t < 2; t++) begin
         wb = (t == 0) ? 5'd0 : 5'd31;
         w0 = (t == 0) ? 32'hDEAD_BEEF : 32'h0F1E_2D3C;
         w1 = (t == 0) ? 32'h1357_9BDF : 32'hF0E1_D2C3;
         drive_frame(wb, 8'd0, 1'b0, w0, w1);
         bus.start = 1'b1;
         tick;
         bus.start = 1'b0;
         for (int i = 1; i <= 66; i++) begin
            exp = {1'b1, exp_vec(i, 24, 0, 1'b0, w0, w1)};
            tests_run++;
            if ({bus.busy, bus.bck, bus.le, bus.sdata} !== exp) begin
               tests_failed++;
               $display("FAIL word_bits_%0d i=%0d got=%b exp=%b", wb, i, {bus.busy, bus.bck, bus.le, bus.sdata}, exp);
            end
            tick;
         end
         tests_run++;
         if (bus.busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL word_bits_%0d_end busy got=%b exp=0", wb, bus.busy);
         end
         tick;
      end
   endtask

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      reset        = 1'b1;
      bus.start    = 1'b0;
      drive_frame(5'd0, 8'd0, 1'b0, 32'h0, 32'h0);
`ifdef NOS_DAC_SER_MUTE_EN
      bus.mute     = 1'b0;
`endif
      test_reset();
      test_basic();
      test_cont();
      test_back_to_back();
      test_latch_start();
      test_reset_mid();
      test_word_bits();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/nos_dac_serializer.md
# nos_dac_serializer

Parametrised non-oversampling DAC serializer: the next-generation replacement for the fixed two-channel NOS half-mode shifter. It takes one frame of CHANNELS PCM words and emits one serial data line per channel, together with a shared bit clock and latch-enable, in the ladder-DAC "right-justified, latch at end" format. It adds a programmable bit-clock divider and a one-frame holding buffer so frames can run back to back without gaps. It sits between the I2S receiver/FIFO and the DAC chip pins in the transceiver.

## Interface
- CHANNELS, 2: number of serial data outputs.
- IN_BITS, 32: width of each input channel word.
- MAX_BITS, 24: maximum DAC word length.
- DIV_W, 8: width of the half-period divider input.

- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- data  in  CHANNELS*IN_BITS  channel k at [k*IN_BITS +: IN_BITS], MSB-aligned PCM.
- start  in  1  frame strobe; data is valid while start=1.
- ready  out  1  holding buffer empty; start is accepted only when ready=1.
- word_bits  in  5  DAC word length N; 0 or >MAX_BITS is treated as MAX_BITS.
- half_div  in  DIV_W  bck half-period = half_div+1 clk cycles.
- bck_cont  in  1  1 = bck also toggles during padding periods.
- bck  out  1  DAC bit clock.
- sdata  out  CHANNELS  serial data, one bit per channel.
- le  out  1  latch enable.
- busy  out  1  a frame is being shifted.
- overrun  out  1  one-cycle pulse when start is asserted with ready=0 (frame dropped).

## Operation
- A frame consists of 33 bck periods: (32-N) PAD periods, N DATA periods, then 1 LATCH period. Each period is a low half followed by a high half.
- FSM states:
  - IDLE -> PAD on start accept; PAD goes to DATA when N=32 would leave zero pad periods, which cannot occur since N≤24 for MAX_BITS=24.
  - PAD -> DATA after 32-N periods.
  - DATA -> LATCH after N periods.
  - LATCH -> PAD if the holding buffer is full or an accepting start coincides with LATCH end; otherwise LATCH -> IDLE.
- Frame load samples word_bits, half_div, bck_cont and channel words; each shift register gets data[k*IN_BITS+IN_BITS-1 -: N]. Mid-frame changes to these inputs are ignored.
- PAD: sdata=0, le=0; bck toggles if bck_cont=1, otherwise it is held at 0.
- DATA: sdata[k] carries the channel-k bit MSB first. The bit changes at the start of the low half and shifts at the end of the high half; bck toggles.
- LATCH: le=1 for both halves, bck toggles, sdata holds the LSB.
- start with ready=1:
  - In IDLE, or in the last cycle of LATCH: data loads directly into the shifter and ready stays 1.
  - Otherwise: data goes into the holding buffer, and ready=0 from the next cycle until that buffer moves into the shifter.
- start with ready=0: data is discarded, overrun=1 for one cycle, and shifter state is unaffected.
- busy=1 in PAD, DATA and LATCH.

## Timing
- Reset values: bck=0, sdata=0, le=0, ready=1, busy=0, overrun=0. The holding buffer is cleared and the FSM returns to IDLE. Reset mid-frame forces these values immediately (asynchronously).
- All outputs are registered.
- Latency: for a start accepted at edge t in IDLE, busy=1 and the first PAD low half are visible from t+1.
- Frame length is 66*(half_div+1) clk cycles. Back-to-back frames have no idle cycle between the LATCH high half and the next PAD low half.
- ready returns to 1 in the cycle after the buffer-to-shifter transfer.

## Configuration
- NOS_DAC_SER_MUTE_EN: when defined, adds input port mute (1 bit). If mute=1 at frame load, all channel shift registers load 0, and frame timing is unchanged.
- When not defined, the port does not exist and data is always passed through.

## Test plan
- Reset, then start with N=16, half_div=0, bck_cont=0, channel0=0xA5A5_0000, channel1=0x1234_0000.
  - Required: 16 PAD periods with bck=0, then DATA sdata[0] = A5A5 MSB first and sdata[1] = 1234, then le=1 for 2 cycles.
  - busy drops after 66 cycles.
- Same stimulus with bck_cont=1, N=24, half_div=3.
  - Required: 33 full bck periods of 8 clk each, 8 PAD periods, and 264 cycles total.
- Second start during frame 1, third start while ready=0.
  - Required: frame 2 follows with no gap, the third start gives overrun=1 for exactly 1 cycle, and frame 3 is never output.
- start in the last LATCH cycle with the buffer empty.
  - Required: the next PAD low half begins on the next cycle and ready stays 1.
- Assert reset in the middle of DATA.
  - Required: all outputs read reset values immediately; a new start afterwards produces a correct complete frame.
- word_bits=0 and word_bits=31.
  - Required: both behave as N=24.
